prog_mem_loader: RTL and testbench

Parametrised program memory with a byte-serial boot loader and core run control. It replaces the fixed 14-bit, read-only program memory in front of rv32i_core. Bytes from a host link, such as a UART receiver, are assembled little-endian into 32-bit words and written from word 0. The block holds the core in reset with its clock enable off until the load completes, then serves instruction fetches with one-cycle read latency.

---
 rtl/prog_mem_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Program memory with a byte-serial little-endian boot loader and core run control.
// Define LOADER_CHECKSUM_EN to require an 8-bit checksum trailer byte after each load.
module prog_mem_loader #(
    parameter int ADDR_W   = 14,
    parameter int LEN_W    = 13,
    parameter int RST_HOLD = 2
) (
    input  logic              clk_i,
    input  logic              rstB_i,
    input  logic              load_start_i,
    input  logic [LEN_W-1:0]  load_len_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [31:0]       inst_out_o,
    output logic              core_rstB_o,
    output logic              core_clkEn_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              misalign_o,
    output logic              cksum_err_o
);
    localparam int WA_W   = ADDR_W - 2;
    localparam int DEPTH  = 1 << WA_W;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_CKERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [23:0]        asm_q, asm_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        inst_q;
    logic               can_start;
    logic               mem_we;
    logic [31:0]        mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
    logic               trailer_q, trailer_d;
    logic [7:0]         ck_sum;
`endif

    logic [31:0] mem [DEPTH];

    // Memory has no reset; reads are read-first against a same-cycle write.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wcnt_q[WA_W-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rstB_i) begin
        if (!rstB_i) begin
            inst_q <= '0;
        end else if (state_q == S_RUN) begin
            inst_q <= mem[pc_i[ADDR_W-1:2]];
        end
    end

    always_ff @(posedge clk_i or negedge rstB_i) begin
        if (!rstB_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            hold_q     <= '0;
            misalign_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            trailer_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            hold_q     <= hold_d;
            misalign_q <= misalign_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            trailer_q  <= trailer_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        bcnt_d     = bcnt_q;
        asm_d      = asm_q;
        hold_d     = hold_q;
        misalign_d = misalign_q;
        mem_we     = 1'b0;
        mem_wdata  = {byte_in_i, asm_q};
        can_start  = (state_q == S_IDLE) || (state_q == S_RUN);
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        trailer_d  = trailer_q;
        ck_sum     = sum_q + byte_in_i;
        if (state_q == S_CKERR) can_start = 1'b1;
`endif

        case (state_q)
            S_LOAD: begin
                if (byte_valid_i) begin
`ifdef LOADER_CHECKSUM_EN
                    if (trailer_q) begin
                        state_d = (ck_sum == 8'd0) ? S_RELEASE : S_CKERR;
                    end else begin
                        sum_d = ck_sum;
`endif
                        // Shift right so byte k ends up in bits [8k+7:8k] after byte 3 arrives.
                        asm_d  = {byte_in_i, asm_q[23:8]};
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            mem_we = 1'b1;
                            wcnt_d = wcnt_q + LEN_W'(1);
                            if (wcnt_q == len_q - LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                                trailer_d = 1'b1;
`else
                                state_d = S_RELEASE;
`endif
                            end
                        end
`ifdef LOADER_CHECKSUM_EN
                    end
`endif
                end
            end
            S_RELEASE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (pc_i[1:0] != 2'b00) misalign_d = 1'b1;
            end
            default: begin
            end
        endcase

        if (can_start && load_start_i) begin
            len_d      = (load_len_i > DEPTH_LEN) ? DEPTH_LEN : load_len_i;
            wcnt_d     = '0;
            bcnt_d     = '0;
            asm_d      = '0;
            hold_d     = '0;
            misalign_d = 1'b0;
            state_d    = (len_d == '0) ? S_RELEASE : S_LOAD;
`ifdef LOADER_CHECKSUM_EN
            sum_d      = '0;
            trailer_d  = 1'b0;
`endif
        end

        byte_ready_o = (state_q == S_LOAD);
        core_rstB_o  = (state_q == S_RUN);
        core_clkEn_o = (state_q == S_RUN);
        load_busy_o  = (state_q == S_LOAD) || (state_q == S_RELEASE);
        load_done_o  = (state_q == S_RUN);
        misalign_o   = misalign_q;
`ifdef LOADER_CHECKSUM_EN
        cksum_err_o  = (state_q == S_CKERR);
`else
        cksum_err_o  = 1'b0;
`endif
    end

    assign inst_out_o = inst_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised self-checking bench for prog_mem_loader against a byte-queue reference model.
module tb_prog_mem_loader;
    localparam int ADDR_W   = 6;
    localparam int LEN_W    = 8;
    localparam int RST_HOLD = 2;
    localparam int DEPTH    = 1 << (ADDR_W - 2);
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_CKERR = 4;

    logic              clk_i = 1'b0;
    logic              rstB_i;
    logic              load_start_i;
    logic [LEN_W-1:0]  load_len_i;
    logic [7:0]        byte_in_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic [ADDR_W-1:0] pc_i;
    logic [31:0]       inst_out_o;
    logic              core_rstB_o;
    logic              core_clkEn_o;
    logic              load_busy_o;
    logic              load_done_o;
    logic              misalign_o;
    logic              cksum_err_o;

    prog_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RST_HOLD(RST_HOLD)) dut (
        .clk_i(clk_i), .rstB_i(rstB_i), .load_start_i(load_start_i), .load_len_i(load_len_i),
        .byte_in_i(byte_in_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .pc_i(pc_i), .inst_out_o(inst_out_o), .core_rstB_o(core_rstB_o),
        .core_clkEn_o(core_clkEn_o), .load_busy_o(load_busy_o), .load_done_o(load_done_o),
        .misalign_o(misalign_o), .cksum_err_o(cksum_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          ph = P_IDLE;
    int          need = 0;
    int          rel_left = 0;
    logic [7:0]  bq[$];
    logic        mis = 1'b0;
    logic [31:0] exp_inst = '0;
    bit          inst_known = 1'b1;
    logic [31:0] mem_model [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge from the inputs the DUT samples there.
    initial begin
        int k;
        int total;
        logic [7:0] s;
        forever begin
            @(posedge clk_i);
            if (!rstB_i) begin
                ph = P_IDLE; bq.delete(); mis = 1'b0; exp_inst = '0; inst_known = 1'b1;
                need = 0; rel_left = 0;
            end else begin
                case (ph)
                    P_LOAD: begin
                        if (byte_valid_i) begin
                            bq.push_back(byte_in_i);
                            if (bq.size() % 4 == 0 && bq.size() <= 4 * need) begin
                                k = bq.size() / 4 - 1;
                                mem_model[k] = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
                            end
                            total = 4 * need + (CK ? 1 : 0);
                            if (bq.size() == total) begin
                                s = 8'd0;
                                foreach (bq[i]) s = s + bq[i];
                                ph = (!CK || s == 8'd0) ? P_REL : P_CKERR;
                                rel_left = RST_HOLD;
                            end
                        end
                    end
                    P_REL: begin
                        rel_left--;
                        if (rel_left == 0) ph = P_RUN;
                    end
                    default: begin
                        if (ph == P_RUN) begin
                            k = int'(pc_i) / 4;
                            if (mem_model.exists(k)) begin
                                exp_inst = mem_model[k]; inst_known = 1'b1;
                            end else begin
                                inst_known = 1'b0;
                            end
                            if (pc_i[1:0] != 2'b00) mis = 1'b1;
                        end
                        if (load_start_i) begin
                            need = (int'(load_len_i) > DEPTH) ? DEPTH : int'(load_len_i);
                            bq.delete();
                            mis = 1'b0;
                            rel_left = RST_HOLD;
                            ph = (need == 0) ? P_REL : P_LOAD;
                        end
                    end
                endcase
            end
        end
    end

    // Every falling edge: all outputs against the model.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstB_i) begin
                check("rst_byte_ready", 32'(byte_ready_o), 32'd0);
                check("rst_core_rstB",  32'(core_rstB_o),  32'd0);
                check("rst_core_clkEn", 32'(core_clkEn_o), 32'd0);
                check("rst_load_busy",  32'(load_busy_o),  32'd0);
                check("rst_load_done",  32'(load_done_o),  32'd0);
                check("rst_misalign",   32'(misalign_o),   32'd0);
                check("rst_cksum_err",  32'(cksum_err_o),  32'd0);
                check("rst_inst_out",   inst_out_o,        32'd0);
            end else begin
                check("byte_ready", 32'(byte_ready_o), 32'(ph == P_LOAD));
                check("core_rstB",  32'(core_rstB_o),  32'(ph == P_RUN));
                check("core_clkEn", 32'(core_clkEn_o), 32'(ph == P_RUN));
                check("load_busy",  32'(load_busy_o),  32'(ph == P_LOAD || ph == P_REL));
                check("load_done",  32'(load_done_o),  32'(ph == P_RUN));
                check("misalign",   32'(misalign_o),   32'(mis));
                check("cksum_err",  32'(cksum_err_o),  32'(ph == P_CKERR));
                if (inst_known) check("inst_out", inst_out_o, exp_inst);
            end
        end
    end

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic reset_dut();
        #2 rstB_i = 1'b0;
        cyc(); cyc();
        #2 rstB_i = 1'b1;
        cyc();
    endtask

    task automatic pulse_start(input int len);
        load_start_i = 1'b1;
        load_len_i   = LEN_W'(len);
        cyc();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            byte_valid_i = 1'b0;
            byte_in_i    = 8'($urandom);
            cyc();
            load_start_i = 1'b0;
        end
        byte_valid_i = 1'b1;
        byte_in_i    = b;
        cyc();
        byte_valid_i = 1'b0;
    endtask

    // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps plus stray load_start pulses
    task automatic load_words(input logic [31:0] w[$], input int len, input int gapmode, input bit bad_ck);
        int n;
        int gap;
        logic [31:0] tmp;
        logic [7:0] b;
        logic [7:0] s;
        n = (len > DEPTH) ? DEPTH : len;
        s = 8'd0;
        for (int i = 0; i < n * 4; i++) begin
            tmp = w[i / 4];
            b   = 8'(tmp >> (8 * (i % 4)));
            s   = s + b;
            gap = (gapmode == 1) ? 1 : ((gapmode == 2) ? int'($urandom_range(0, 2)) : 0);
            if (gapmode == 2 && gap > 0 && $urandom_range(0, 7) == 0) begin
                load_start_i = 1'b1;
                load_len_i   = LEN_W'($urandom);
            end
            send_byte(b, gap);
        end
        if (CK && n > 0) begin
            b = -s;
            if (bad_ck) b = b + 8'd1;
            send_byte(b, (gapmode == 0) ? 0 : 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wq[$];
        int cnt;
        int len;
        rstB_i = 1'b1; load_start_i = 1'b0; load_len_i = '0; byte_in_i = '0;
        byte_valid_i = 1'b0; pc_i = '0;
        #1 rstB_i = 1'b0;
        cyc(); cyc();
        #2 rstB_i = 1'b1;
        cyc();

        // Test 1: two-word load, release timing
        wq = {32'h00000013, 32'h00100093};
        pulse_start(2);
        load_words(wq, 2, 0, 1'b0);
        check("t1_ready_drop", 32'(byte_ready_o), 32'd0);
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (core_rstB_o) begin
                cnt = i;
                break;
            end
        end
        check("t1_release_cycles", cnt, RST_HOLD);
        check("t1_clken_with_rstB", 32'(core_clkEn_o), 32'd1);
        check("t1_model_w0", mem_model[0], 32'h00000013);
        check("t1_model_w1", mem_model[1], 32'h00100093);

        // Test 2: fetch pc 0,4,0
        pc_i = 6'd0; cyc(); check("t2_fetch0", inst_out_o, 32'h00000013);
        pc_i = 6'd4; cyc(); check("t2_fetch4", inst_out_o, 32'h00100093);
        pc_i = 6'd0; cyc(); check("t2_fetch0b", inst_out_o, 32'h00000013);

        // Test 3: same load with byte_valid toggling, reloaded from RUN
        pulse_start(2);
        load_words(wq, 2, 1, 1'b0);
        repeat (RST_HOLD) cyc();
        pc_i = 6'd4; cyc(); check("t3_fetch4", inst_out_o, 32'h00100093);
        pc_i = 6'd0; cyc(); check("t3_fetch0", inst_out_o, 32'h00000013);

        // Test 4: zero-length load from IDLE runs existing contents
        reset_dut();
        pulse_start(0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        check("t4_run", 32'(load_done_o), 32'd1);
        pc_i = 6'd4; cyc(); check("t4_fetch4", inst_out_o, 32'h00100093);

        // Test 5: misalign, then reset part-way through a word
        pc_i = 6'd6; cyc();
        check("t5_misalign_set", 32'(misalign_o), 32'd1);
        pulse_start(1);
        check("t5_misalign_clr", 32'(misalign_o), 32'd0);
        check("t5_clken_off", 32'(core_clkEn_o), 32'd0);
        check("t5_loading", 32'(byte_ready_o), 32'd1);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        reset_dut();
        check("t5_held", 32'(core_rstB_o), 32'd0);
        check("t5_idle", 32'(load_busy_o), 32'd0);
        pc_i = 6'd0;
        pulse_start(0);
        repeat (RST_HOLD) cyc();
        cyc();
        check("t5_word_kept", inst_out_o, 32'h00000013);

`ifdef LOADER_CHECKSUM_EN
        // Test 6: good and bad checksum trailers
        wq = {32'h00000013};
        pulse_start(1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hED, 0);
        repeat (RST_HOLD) cyc();
        check("t6_good_run", 32'(load_done_o), 32'd1);
        pulse_start(1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEE, 0);
        repeat (3) cyc();
        check("t6_cksum_err", 32'(cksum_err_o), 32'd1);
        check("t6_core_held", 32'(core_rstB_o), 32'd0);
        pulse_start(0);
        check("t6_err_cleared", 32'(cksum_err_o), 32'd0);
        repeat (RST_HOLD) cyc();
`endif

        // Length clamp: more words requested than the memory holds
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        pulse_start(DEPTH + 5);
        load_words(wq, DEPTH + 5, 0, 1'b0);
        repeat (RST_HOLD) cyc();
        check("clamp_run", 32'(load_done_o), 32'd1);
        pc_i = ADDR_W'((DEPTH - 1) * 4); cyc();
        check("clamp_last_word", inst_out_o, wq[DEPTH - 1]);

        // Randomised loads and fetches
        for (int it = 0; it < 14; it++) begin
            wq.delete();
            for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
            len = int'($urandom_range(0, DEPTH + 3));
            pulse_start(len);
            load_words(wq, len, 2, ($urandom_range(0, 4) == 0));
            repeat (RST_HOLD + 1) cyc();
            for (int j = 0; j < 20; j++) begin
                if ($urandom_range(0, 9) == 0) pc_i = ADDR_W'($urandom);
                else pc_i = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
                byte_valid_i = 1'($urandom);
                byte_in_i    = 8'($urandom);
                cyc();
            end
            byte_valid_i = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
